// File: rtl/grill_scheduler.sv
// grill_scheduler: per-slot steak cooking FSMs driven by the one-per-second tick,
// with a one-command-per-cycle player command port (place/flip/serve/discard).
// Slot state, counters and underdone flags update one cycle after a tick or command.
// Command responses (ack/err/serve) are registered and appear one cycle after acceptance.
module grill_scheduler #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2,
   parameter int SIDE_TIME = 5,
   parameter int BURN_TIME = 3,
   parameter int CNT_W     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick,
   input  logic                   cmd_valid,
   input  logic [1:0]             cmd_op,
   input  logic [SLOT_W-1:0]      cmd_slot,
   output logic                   cmd_ready,
   output logic                   cmd_ack,
   output logic                   cmd_err,
   output logic [3*NUM_SLOTS-1:0] slot_state,
   output logic                   served_pulse,
   output logic [1:0]             served_quality
);

   typedef enum logic [2:0] {
      ST_EMPTY = 3'd0,
      ST_SIDE1 = 3'd1,
      ST_SIDE2 = 3'd2,
      ST_READY = 3'd3,
      ST_BURNT = 3'd4
   } slot_st_t;

   typedef enum logic [1:0] {
      OP_PLACE   = 2'b00,
      OP_FLIP    = 2'b01,
      OP_SERVE   = 2'b10,
      OP_DISCARD = 2'b11
   } op_t;

   localparam logic [CNT_W-1:0] SIDE_LIM  = CNT_W'(SIDE_TIME);
   localparam logic [CNT_W-1:0] BURN_LIM  = CNT_W'(BURN_TIME);
   localparam logic [CNT_W-1:0] CHAR_LIM  = CNT_W'(SIDE_TIME + BURN_TIME);

   // Tick counters saturate at all-ones so a held slot can never wrap back.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   slot_st_t         st      [NUM_SLOTS];
   logic [CNT_W-1:0] cnt     [NUM_SLOTS];
   logic             und     [NUM_SLOTS];
   logic [CNT_W-1:0] cnt_inc [NUM_SLOTS];

   logic             rdy_arm_p1;
   logic             acc_p0;
   logic             slot_ok_p0;
   logic             op_ok_p0;
   logic             legal_p0;
   slot_st_t         tgt_st_p0;
   logic [CNT_W-1:0] tgt_cnt_p0;
   logic             tgt_und_p0;
   op_t              op_p0;

   // ---- stage p0: decode the incoming command against the targeted slot ----
   always_comb begin
      op_p0      = op_t'(cmd_op);
      acc_p0     = cmd_valid & cmd_ready;
      slot_ok_p0 = (int'(cmd_slot) < NUM_SLOTS);
      tgt_st_p0  = ST_EMPTY;
      tgt_cnt_p0 = '0;
      tgt_und_p0 = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (cmd_slot == SLOT_W'(i)) begin
            tgt_st_p0  = st[i];
            tgt_cnt_p0 = cnt[i];
            tgt_und_p0 = und[i];
         end
      end
      op_ok_p0 = 1'b0;
      case (op_p0)
         OP_PLACE:   op_ok_p0 = (tgt_st_p0 == ST_EMPTY);
         OP_FLIP:    op_ok_p0 = (tgt_st_p0 == ST_SIDE1);
         OP_SERVE:   op_ok_p0 = (tgt_st_p0 == ST_READY);
         OP_DISCARD: op_ok_p0 = (tgt_st_p0 != ST_EMPTY);
         default:    op_ok_p0 = 1'b0;
      endcase
      legal_p0 = acc_p0 & slot_ok_p0 & op_ok_p0;
   end

   // Precompute the saturated next count for every slot.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt_inc[i] = sat_inc(cnt[i]);
      end
   end

   // ---- stage p1: per-slot cooking FSMs; a command on a slot pre-empts its tick ----
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            st[i]  <= ST_EMPTY;
            cnt[i] <= '0;
            und[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (acc_p0 && slot_ok_p0 && (cmd_slot == SLOT_W'(i))) begin
               if (legal_p0) begin
                  case (op_p0)
                     OP_PLACE: begin
                        st[i]  <= ST_SIDE1;
                        cnt[i] <= '0;
                        und[i] <= 1'b0;
                     end
                     OP_FLIP: begin
                        st[i]  <= ST_SIDE2;
                        cnt[i] <= '0;
                        und[i] <= (cnt[i] < SIDE_LIM);
                     end
                     OP_SERVE: begin
                        st[i]  <= ST_EMPTY;
                        cnt[i] <= '0;
                     end
                     default: begin
                        st[i]  <= ST_EMPTY;
                        cnt[i] <= '0;
                     end
                  endcase
               end
            end else if (tick) begin
               case (st[i])
                  ST_SIDE1: begin
                     cnt[i] <= cnt_inc[i];
                     if (cnt_inc[i] == CHAR_LIM) st[i] <= ST_BURNT;
                  end
                  ST_SIDE2: begin
                     if (cnt_inc[i] == SIDE_LIM) begin
                        st[i]  <= ST_READY;
                        cnt[i] <= '0;
                     end else begin
                        cnt[i] <= cnt_inc[i];
                     end
                  end
                  ST_READY: begin
                     cnt[i] <= cnt_inc[i];
                     if (cnt_inc[i] == BURN_LIM) st[i] <= ST_BURNT;
                  end
                  default: begin
                     cnt[i] <= cnt[i];
                  end
               endcase
            end
         end
      end
   end

   // ---- stage p1: registered ready, command response and serve result ----
   always_ff @(posedge clk) begin
      if (reset) begin
         rdy_arm_p1     <= 1'b0;
         cmd_ready      <= 1'b0;
         cmd_ack        <= 1'b0;
         cmd_err        <= 1'b0;
         served_pulse   <= 1'b0;
         served_quality <= 2'b00;
      end else begin
         rdy_arm_p1     <= 1'b1;
         cmd_ready      <= rdy_arm_p1;
         cmd_ack        <= legal_p0;
         cmd_err        <= acc_p0 & ~legal_p0;
         served_pulse   <= legal_p0 && (op_p0 == OP_SERVE);
         if (legal_p0 && (op_p0 == OP_SERVE))
            served_quality <= tgt_und_p0 ? 2'b01 : 2'b11;
         else
            served_quality <= 2'b00;
      end
   end

   // Flatten slot states for the display logic, slot i at [3i+2:3i].
   always_comb begin
      slot_state = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_state[3*i +: 3] = st[i];
      end
   end

   // The count carried into a flip only matters through the underdone flag.
   logic unused_tgt_cnt;
   assign unused_tgt_cnt = ^tgt_cnt_p0;

endmodule

// File: tb/tb_grill_scheduler.sv
// Bench for grill_scheduler: expected command responses are queued as each cycle is
// driven and popped when the response appears; slot states are checked against constants.
module tb_grill_scheduler;

   localparam int NS = 4;
   localparam int SW = 3;

   localparam logic [1:0] PLACE = 2'b00;
   localparam logic [1:0] FLIP  = 2'b01;
   localparam logic [1:0] SERVE = 2'b10;
   localparam logic [1:0] DISC  = 2'b11;

   // Response word: {ack, err, served_pulse, served_quality[1:0]}
   localparam logic [4:0] E_NONE  = 5'b00000;
   localparam logic [4:0] E_ACK   = 5'b10000;
   localparam logic [4:0] E_ERR   = 5'b01000;
   localparam logic [4:0] E_SRV11 = 5'b10111;
   localparam logic [4:0] E_SRV01 = 5'b10101;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            tick = 1'b0;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd_op = 2'b00;
   logic [SW-1:0]   cmd_slot = '0;
   logic            cmd_ready;
   logic            cmd_ack;
   logic            cmd_err;
   logic [3*NS-1:0] slot_state;
   logic            served_pulse;
   logic [1:0]      served_quality;

   int n_tot = 0;
   int n_bad = 0;
   logic [4:0] sb[$];

   grill_scheduler #(
      .NUM_SLOTS(NS), .SLOT_W(SW), .SIDE_TIME(5), .BURN_TIME(3), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_slot(cmd_slot),
      .cmd_ready(cmd_ready), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
      .slot_state(slot_state), .served_pulse(served_pulse),
      .served_quality(served_quality)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle from a negedge, queue the expected response, compare at the next negedge.
   task automatic cyc(input string tag, input logic v, input logic [1:0] op, input int slot,
                      input logic tk, input logic [4:0] e);
      logic [4:0] exp;
      cmd_valid = v;
      cmd_op    = op;
      cmd_slot  = SW'(slot);
      tick      = tk;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      exp = sb.pop_front();
      chk(tag, {27'd0, cmd_ack, cmd_err, served_pulse, served_quality}, {27'd0, exp});
   endtask

   task automatic cmd(input string tag, input logic [1:0] op, input int slot, input logic [4:0] e);
      cyc(tag, 1'b1, op, slot, 1'b0, e);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) cyc("tick_resp", 1'b0, PLACE, 0, 1'b1, E_NONE);
   endtask

   task automatic do_reset();
      reset = 1'b1; cmd_valid = 1'b0; tick = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_ready0", {31'd0, cmd_ready}, 32'd0);
      chk("rst_state", {20'd0, slot_state}, 32'd0);
      chk("rst_resp", {27'd0, cmd_ack, cmd_err, served_pulse, served_quality}, 32'd0);
      reset = 1'b0; tick = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_ready1", {31'd0, cmd_ready}, 32'd0);
      chk("rst_nosrv", {31'd0, served_pulse}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("rst_ready2", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Place on slot 2.
      cmd("place2", PLACE, 2, E_ACK);
      chk("place2_st", {20'd0, slot_state}, 32'h040);
      cmd("disc2", DISC, 2, E_ACK);
      chk("disc2_st", {20'd0, slot_state}, 32'h000);

      // Fully cooked steak on slot 0.
      cmd("place0", PLACE, 0, E_ACK);
      ticks(5);
      chk("s0_side1", {20'd0, slot_state}, 32'h001);
      cmd("flip0", FLIP, 0, E_ACK);
      chk("s0_side2", {20'd0, slot_state}, 32'h002);
      ticks(4);
      chk("s0_side2_4", {20'd0, slot_state}, 32'h002);
      ticks(1);
      chk("s0_ready", {20'd0, slot_state}, 32'h003);
      cmd("serve0", SERVE, 0, E_SRV11);
      chk("serve0_st", {20'd0, slot_state}, 32'h000);

      // Underdone first side on slot 1.
      cmd("place1", PLACE, 1, E_ACK);
      ticks(2);
      cmd("flip1", FLIP, 1, E_ACK);
      ticks(5);
      chk("s1_ready", {20'd0, slot_state}, 32'h018);
      cmd("serve1", SERVE, 1, E_SRV01);

      // Slot 3 left on side 1 burns after 8 ticks.
      cmd("place3", PLACE, 3, E_ACK);
      ticks(7);
      chk("s3_side1_7", {20'd0, slot_state}, 32'h200);
      ticks(1);
      chk("s3_burnt", {20'd0, slot_state}, 32'h800);
      cmd("serve3_bad", SERVE, 3, E_ERR);
      chk("s3_still_burnt", {20'd0, slot_state}, 32'h800);
      ticks(4);
      chk("s3_hold", {20'd0, slot_state}, 32'h800);
      cmd("disc3", DISC, 3, E_ACK);

      // Illegal commands leave state unchanged.
      cmd("flip_empty", FLIP, 0, E_ERR);
      chk("flip_empty_st", {20'd0, slot_state}, 32'h000);
      cmd("place0b", PLACE, 0, E_ACK);
      cmd("place_occ", PLACE, 0, E_ERR);
      chk("place_occ_st", {20'd0, slot_state}, 32'h001);
      cmd("slot4", PLACE, 4, E_ERR);
      chk("slot4_st", {20'd0, slot_state}, 32'h001);
      cmd("serve_side1", SERVE, 0, E_ERR);
      cmd("disc0", DISC, 0, E_ACK);

      // Command and tick in the same cycle: slot 0 skips the tick, slot 1 advances.
      cmd("place1b", PLACE, 1, E_ACK);
      ticks(2);
      cyc("place0_tick", 1'b1, PLACE, 0, 1'b1, E_ACK);
      ticks(4);
      chk("mix_a", {20'd0, slot_state}, 32'h009);
      ticks(1);
      chk("mix_s1_burnt", {20'd0, slot_state}, 32'h021);
      ticks(2);
      chk("mix_s0_cnt7", {20'd0, slot_state}, 32'h021);
      ticks(1);
      chk("mix_s0_burnt", {20'd0, slot_state}, 32'h024);

      // Reset mid-cook with a ready steak waiting.
      cmd("place2b", PLACE, 2, E_ACK);
      cmd("flip2b", FLIP, 2, E_ACK);
      ticks(5);
      chk("s2_ready", {20'd0, slot_state}, 32'h0E4);
      do_reset();
      cmd("post_rst_place", PLACE, 2, E_ACK);
      chk("post_rst_st", {20'd0, slot_state}, 32'h040);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
